rs_entry_replay: RTL

- Parametrised next-generation reservation-station entry. One instance holds one renamed uop from dispatch until it completes safely.
- Tracks N source operands against M PRF write-back ports, and gates issue on a configurable set of structural blockers.
- Keeps the uop after grant for a speculative shadow window, so a replay request from execute can re-arm it instead of losing it.
- An RS array instantiates RS_DEPTH copies behind its age-based picker.

---
 rtl/rs_defs.sv | 26 ++
 rtl/rs_src_wakeup.sv | 68 ++++++
 rtl/rs_entry_replay.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/rs_defs.sv
// Shared definitions for the reservation-station entry.
//   t_rs_state    : entry lifecycle states
//   t_rs_src_trk  : per-source tracking record {pend, psrc}
//   BLK_STQ/LDQ   : default bit positions in the structural blocker vector
// psrc is stored at RS_PREG_W_MAX bits so the record stays a fixed type
// while PREG_W remains a parameter; narrower indices are zero-extended.
package rs_defs;

    localparam int RS_PREG_W_MAX = 12;

    localparam int BLK_STQ = 0;
    localparam int BLK_LDQ = 1;

    typedef enum logic [1:0] {
        RS_IDLE    = 2'd0,
        RS_WAIT    = 2'd1,
        RS_SHADOW  = 2'd2,
        RS_BACKOFF = 2'd3
    } t_rs_state;

    typedef struct packed {
        logic                     pend;
        logic [RS_PREG_W_MAX-1:0] psrc;
    } t_rs_src_trk;

endpackage

// File: rtl/rs_src_wakeup.sv
// One source-operand tracker for a reservation-station entry.
// Ports:
//   clk, reset  : clock, async active-high reset
//   load        : entry is being allocated this cycle
//   track       : entry occupied, wakeup compare active
//   load_psrc   : source preg presented with alloc
//   load_pend   : 1 = source not yet written at alloc
//   wr_en       : PRF write valid, per port
//   wr_preg     : PRF write index, per port
//   ready       : source operand available
module rs_src_wakeup
    import rs_defs::*;
#(
    parameter int NUM_WR_PORTS = 2,
    parameter int PREG_W       = 7
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 load,
    input  logic                                 track,
    input  logic [PREG_W-1:0]                    load_psrc,
    input  logic                                 load_pend,
    input  logic [NUM_WR_PORTS-1:0]              wr_en,
    input  logic [NUM_WR_PORTS-1:0][PREG_W-1:0]  wr_preg,
    output logic                                 ready
);

    if (PREG_W > RS_PREG_W_MAX || PREG_W < 1) begin : g_bad_preg_w
        $error("rs_src_wakeup: PREG_W out of range");
    end

    t_rs_src_trk trk;

    function automatic logic wr_hit(input logic [RS_PREG_W_MAX-1:0] psrc,
                                    input logic [NUM_WR_PORTS-1:0] en,
                                    input logic [NUM_WR_PORTS-1:0][PREG_W-1:0] preg);
        logic h;
        h = 1'b0;
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            if (en[p] && (RS_PREG_W_MAX'(preg[p]) == psrc)) h = 1'b1;
        end
        return h;
    endfunction

    logic [RS_PREG_W_MAX-1:0] load_psrc_ext;
    logic                     load_hit;
    logic                     trk_hit;

    assign load_psrc_ext = RS_PREG_W_MAX'(load_psrc);
    assign load_hit      = wr_hit(load_psrc_ext, wr_en, wr_preg);
    assign trk_hit       = wr_hit(trk.psrc, wr_en, wr_preg);

    // A write landing in the alloc cycle is bypassed so the operand is
    // not left waiting for a broadcast that has already gone by.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trk <= '0;
        end else if (load) begin
            trk.psrc <= load_psrc_ext;
            trk.pend <= load_pend & ~load_hit;
        end else if (track && trk.pend && trk_hit) begin
            trk.pend <= 1'b0;
        end
    end

    assign ready = ~trk.pend;

endmodule

// File: rtl/rs_entry_replay.sv
// Reservation-station entry with speculative replay shadow.
// Holds one renamed uop from dispatch until the shadow window after issue
// closes without a replay; a replay re-arms the entry after a backoff.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | entry empty, accepts alloc
//   WAIT     | uop held, requests issue once sources ready and unblocked
//   SHADOW   | issued, waiting SHADOW_CYC cycles for a possible replay
//   BACKOFF  | replayed, holding off BACKOFF_CYC cycles before re-request
//
// Ports:
//   clk, reset        : clock, async active-high reset
//   nuke              : flush, drops the entry
//   blocker_busy      : structural resource busy flags
//   wr_en, wr_preg    : PRF write-back (wakeup) ports
//   alloc, alloc_*    : dispatch load of a new uop
//   e_valid           : entry occupied
//   e_req_issue       : issue request to picker
//   gnt_issue         : picker grant (same cycle as request)
//   e_issue_payload   : captured payload
//   replay            : execute replay request (SHADOW only)
//   e_free            : one-cycle pulse on return to IDLE
//   e_replay_cnt      : saturating replay count for the held uop
module rs_entry_replay
    import rs_defs::*;
#(
    parameter int NUM_SRCS     = 2,
    parameter int NUM_WR_PORTS = 2,
    parameter int PREG_W       = 7,
    parameter int PAYLOAD_W    = 64,
    parameter int NUM_BLOCKERS = 2,
    parameter int SHADOW_CYC   = 3,
    parameter int BACKOFF_CYC  = 2,
    parameter int REPLAY_CNT_W = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 nuke,
    input  logic [NUM_BLOCKERS-1:0]              blocker_busy,
    input  logic [NUM_WR_PORTS-1:0]              wr_en,
    input  logic [NUM_WR_PORTS-1:0][PREG_W-1:0]  wr_preg,
    input  logic                                 alloc,
    input  logic [NUM_SRCS-1:0][PREG_W-1:0]      alloc_psrc,
    input  logic [NUM_SRCS-1:0]                  alloc_psrc_pend,
    input  logic [NUM_BLOCKERS-1:0]              alloc_block_mask,
    input  logic [PAYLOAD_W-1:0]                 alloc_payload,
    output logic                                 e_valid,
    output logic                                 e_req_issue,
    input  logic                                 gnt_issue,
    output logic [PAYLOAD_W-1:0]                 e_issue_payload,
    input  logic                                 replay,
    output logic                                 e_free,
    output logic [REPLAY_CNT_W-1:0]              e_replay_cnt
);

    if (SHADOW_CYC < 1 || BACKOFF_CYC < 1) begin : g_bad_cyc
        $error("rs_entry_replay: SHADOW_CYC and BACKOFF_CYC must be >= 1");
    end

    localparam int CNT_MAX = (SHADOW_CYC > BACKOFF_CYC) ? SHADOW_CYC : BACKOFF_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SHADOW_LAST  = CNT_W'(SHADOW_CYC - 1);
    localparam logic [CNT_W-1:0] BACKOFF_LAST = CNT_W'(BACKOFF_CYC - 1);

    t_rs_state               state;
    logic [CNT_W-1:0]        cnt;
    logic [NUM_BLOCKERS-1:0] block_mask;
    logic [NUM_SRCS-1:0]     src_ready;
    logic                    load;
    logic                    track;

    assign load  = alloc & ~nuke & (state == RS_IDLE);
    assign track = (state != RS_IDLE);

    for (genvar s = 0; s < NUM_SRCS; s++) begin : g_src
        rs_src_wakeup #(
            .NUM_WR_PORTS (NUM_WR_PORTS),
            .PREG_W       (PREG_W)
        ) u_src (
            .clk       (clk),
            .reset     (reset),
            .load      (load),
            .track     (track),
            .load_psrc (alloc_psrc[s]),
            .load_pend (alloc_psrc_pend[s]),
            .wr_en     (wr_en),
            .wr_preg   (wr_preg),
            .ready     (src_ready[s])
        );
    end

    assign e_valid     = (state != RS_IDLE);
    // Blockers are live so a resource freeing up lets the request rise
    // in the same cycle.
    assign e_req_issue = (state == RS_WAIT) & (&src_ready)
                         & ~|(block_mask & blocker_busy);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= RS_IDLE;
            cnt             <= '0;
            block_mask      <= '0;
            e_issue_payload <= '0;
            e_free          <= 1'b0;
            e_replay_cnt    <= '0;
        end else begin
            e_free <= 1'b0;
            if (nuke) begin
                state  <= RS_IDLE;
                cnt    <= '0;
                e_free <= (state != RS_IDLE);
            end else begin
                case (state)
                    RS_IDLE: begin
                        if (alloc) begin
                            state           <= RS_WAIT;
                            cnt             <= '0;
                            block_mask      <= alloc_block_mask;
                            e_issue_payload <= alloc_payload;
                            e_replay_cnt    <= '0;
                        end
                    end
                    RS_WAIT: begin
                        if (gnt_issue && e_req_issue) begin
                            state <= RS_SHADOW;
                            cnt   <= '0;
                        end
                    end
                    RS_SHADOW: begin
                        // Replay takes priority over the final shadow cycle.
                        if (replay) begin
                            state <= RS_BACKOFF;
                            cnt   <= '0;
                            if (e_replay_cnt != '1) e_replay_cnt <= e_replay_cnt + 1'b1;
                        end else if (cnt == SHADOW_LAST) begin
                            state  <= RS_IDLE;
                            cnt    <= '0;
                            e_free <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RS_BACKOFF: begin
                        if (cnt == BACKOFF_LAST) begin
                            state <= RS_WAIT;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= RS_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

`ifndef SYNTHESIS
    a_gnt_needs_req: assert property (@(posedge clk) disable iff (reset)
        gnt_issue |-> e_req_issue)
        else $error("rs_entry_replay: grant without request");

    a_alloc_when_free: assert property (@(posedge clk) disable iff (reset)
        alloc |-> !e_valid)
        else $error("rs_entry_replay: alloc while entry valid");

    a_replay_in_shadow: assert property (@(posedge clk) disable iff (reset)
        replay |-> (state == RS_SHADOW))
        else $error("rs_entry_replay: replay outside shadow");
`endif

endmodule
